// File: rtl/jtopl_pkg.sv
// Shared definitions for the OPL register write path.
//   - Address-range high nibbles for operator and channel registers.
//   - Slot geometry: 3 groups of 6 subslots, 18 slots per frame.
//   - Bit positions of the update strobes in the one-hot strobe vector.
//   - Write sequencer state encoding.
package jtopl_pkg;

    // High nibble of each register range. Operator ranges span two nibbles
    // (e.g. 0x20-0x35 for MULT), so the odd neighbour is also accepted.
    localparam logic [3:0] OP_MULT  = 4'h2;
    localparam logic [3:0] OP_KSLTL = 4'h4;
    localparam logic [3:0] OP_ARDR  = 4'h6;
    localparam logic [3:0] OP_SLRR  = 4'h8;
    localparam logic [3:0] CH_FNLO  = 4'hA;
    localparam logic [3:0] CH_FNHI  = 4'hB;
    localparam logic [3:0] CH_FBCON = 4'hC;

    localparam int NGROUP = 3;
    localparam int NSUB   = 6;
    localparam int NSLOT  = NGROUP * NSUB;
    localparam int NCHAN  = 9;

    // Position of each update strobe inside the one-hot strobe vector.
    localparam int UP_MULT  = 0;
    localparam int UP_KSLTL = 1;
    localparam int UP_ARDR  = 2;
    localparam int UP_SLRR  = 3;
    localparam int UP_FNLO  = 4;
    localparam int UP_FNHI  = 5;
    localparam int UP_FBCON = 6;
    localparam int NUP      = 7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } wrseq_state_t;

endpackage

// File: rtl/jtopl_wr_decode.sv
// Combinational register-address decoder for the write sequencer.
// Ports:
//   addr   in  8  latched OPL register address
//   strobe out 7  one-hot update strobe (bit order per UP_* in jtopl_pkg)
//   group  out 2  target slot group, 0..2
//   sub    out 3  target subslot, 0..5
//   valid  out 1  address maps to an operator or channel register
module jtopl_wr_decode
    import jtopl_pkg::*;
(
    input  logic [7:0]     addr,
    output logic [NUP-1:0] strobe,
    output logic [1:0]     group,
    output logic [2:0]     sub,
    output logic           valid
);

    logic       op_hit;
    logic       ch_hit;
    logic [2:0] idx;

    always_comb begin
        op_hit = 1'b0;
        ch_hit = 1'b0;
        idx    = 3'd0;
        strobe = '0;
        group  = 2'd0;
        sub    = 3'd0;
        valid  = 1'b0;

        case (addr[7:4])
            OP_MULT,  OP_MULT  | 4'h1: begin op_hit = 1'b1; idx = 3'(UP_MULT);  end
            OP_KSLTL, OP_KSLTL | 4'h1: begin op_hit = 1'b1; idx = 3'(UP_KSLTL); end
            OP_ARDR,  OP_ARDR  | 4'h1: begin op_hit = 1'b1; idx = 3'(UP_ARDR);  end
            OP_SLRR,  OP_SLRR  | 4'h1: begin op_hit = 1'b1; idx = 3'(UP_SLRR);  end
            CH_FNLO:                   begin ch_hit = 1'b1; idx = 3'(UP_FNLO);  end
            CH_FNHI:                   begin ch_hit = 1'b1; idx = 3'(UP_FNHI);  end
            CH_FBCON:                  begin ch_hit = 1'b1; idx = 3'(UP_FBCON); end
            default:                   begin op_hit = 1'b0; ch_hit = 1'b0;     end
        endcase

        if (op_hit) begin
            // Operator offset: bits [4:3] pick the group, [2:0] the subslot.
            // Offsets 6,7 in each group and the whole fourth group are holes.
            group = addr[4:3];
            sub   = addr[2:0];
            valid = (addr[4:3] != 2'd3) && (addr[2:0] < 3'(NSUB));
        end else if (ch_hit) begin
            // Channel n lives at group n/3, subslot n%3.
            group = 2'(addr[3:0] / 4'd3);
            sub   = 3'(addr[3:0] % 4'd3);
            valid = addr[3:0] < 4'(NCHAN);
        end

        if (valid) begin
            strobe[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/jtopl_wrseq.sv
// CPU-side write sequencer for the operator/channel register store.
// An address-port write latches the register address; a data-port write
// with a decodable address raises one update strobe, presents the data
// byte and target slot, and holds them until the slot counter reaches the
// target and the store's update pipeline has drained (HOLD extra cens).
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   cen                 clock enable, one per slot
//   wr, addr, din       bus write strobe, port select (0 addr / 1 data), data
//   zero                store slot counter is at group 0, subslot 0
//   busy                update in flight
//   write               one-clk pulse per accepted data write
//   dout                data byte presented to the store
//   sel_group, sel_sub  target slot of the in-flight update
//   up_*                register update strobes, at most one high
module jtopl_wrseq
    import jtopl_pkg::*;
#(
    parameter int HOLD = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cen,
    input  logic       wr,
    input  logic       addr,
    input  logic [7:0] din,
    input  logic       zero,
    output logic       busy,
    output logic       write,
    output logic [7:0] dout,
    output logic [1:0] sel_group,
    output logic [2:0] sel_sub,
    output logic       up_mult,
    output logic       up_ksl_tl,
    output logic       up_ar_dr,
    output logic       up_sl_rr,
    output logic       up_fnumlo,
    output logic       up_fnumhi,
    output logic       up_fbcon
);

    localparam int HW = (HOLD < 1) ? 1 : $clog2(HOLD + 1);

    wrseq_state_t   state;
    logic [7:0]     addr_q;
    logic [HW-1:0]  hold_cnt;
    logic [NUP-1:0] up_q;

    logic [1:0]     cnt_group;
    logic [2:0]     cnt_sub;
    logic [1:0]     cur_group;
    logic [2:0]     cur_sub;
    logic [1:0]     nxt_group;
    logic [2:0]     nxt_sub;

    logic [NUP-1:0] dec_strobe;
    logic [1:0]     dec_group;
    logic [2:0]     dec_sub;
    logic           dec_valid;

    logic           slot_match;

    jtopl_wr_decode u_decode (
        .addr   (addr_q),
        .strobe (dec_strobe),
        .group  (dec_group),
        .sub    (dec_sub),
        .valid  (dec_valid)
    );

    // Slot tracker. The store's zero flag forces the local count back to
    // slot 0, so the tracker resynchronises once per frame even after a
    // local reset that the store did not see.
    always_comb begin
        cur_group = zero ? 2'd0 : cnt_group;
        cur_sub   = zero ? 3'd0 : cnt_sub;
        if (cur_sub == 3'(NSUB - 1)) begin
            nxt_sub   = 3'd0;
            nxt_group = (cur_group == 2'(NGROUP - 1)) ? 2'd0 : cur_group + 2'd1;
        end else begin
            nxt_sub   = cur_sub + 3'd1;
            nxt_group = cur_group;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_group <= 2'd0;
            cnt_sub   <= 3'd0;
        end else if (cen) begin
            cnt_group <= nxt_group;
            cnt_sub   <= nxt_sub;
        end
    end

    assign slot_match = (cur_group == sel_group) && (cur_sub == sel_sub);

    // Sequencer. Accepts only from IDLE, so an accept and a release can
    // never land on the same clk and at most one strobe is ever high.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            addr_q    <= 8'd0;
            hold_cnt  <= '0;
            up_q      <= '0;
            busy      <= 1'b0;
            write     <= 1'b0;
            dout      <= 8'd0;
            sel_group <= 2'd0;
            sel_sub   <= 3'd0;
        end else begin
            write <= 1'b0;

            // Address-port writes are taken at any time; the decode of an
            // in-flight update was already captured in sel_*/up_q.
            if (wr && !addr) begin
                addr_q <= din;
            end

            case (state)
                ST_IDLE: begin
                    if (wr && addr && dec_valid) begin
                        dout      <= din;
                        sel_group <= dec_group;
                        sel_sub   <= dec_sub;
                        up_q      <= dec_strobe;
                        write     <= 1'b1;
                        busy      <= 1'b1;
                        state     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cen && slot_match) begin
                        hold_cnt <= HW'(HOLD);
                        state    <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    // Keep the strobe up while the target slot walks through
                    // the remaining store pipeline stages.
                    if (cen) begin
                        if (hold_cnt == '0) begin
                            up_q  <= '0;
                            busy  <= 1'b0;
                            state <= ST_IDLE;
                        end else begin
                            hold_cnt <= hold_cnt - HW'(1);
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign up_mult   = up_q[UP_MULT];
    assign up_ksl_tl = up_q[UP_KSLTL];
    assign up_ar_dr  = up_q[UP_ARDR];
    assign up_sl_rr  = up_q[UP_SLRR];
    assign up_fnumlo = up_q[UP_FNLO];
    assign up_fnumhi = up_q[UP_FNHI];
    assign up_fbcon  = up_q[UP_FBCON];

endmodule

// File: tb/tb_jtopl_wrseq.sv
// Bench for jtopl_wrseq: a slot-index / countdown reference model checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_jtopl_wrseq;

    localparam int HOLD  = 3;
    localparam int NSLOT = 18;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cen = 1'b0;
    logic       wr = 1'b0;
    logic       addr = 1'b0;
    logic [7:0] din = 8'h00;
    logic       zero;

    logic       busy, write;
    logic [7:0] dout;
    logic [1:0] sel_group;
    logic [2:0] sel_sub;
    logic       up_mult, up_ksl_tl, up_ar_dr, up_sl_rr;
    logic       up_fnumlo, up_fnumhi, up_fbcon;

    jtopl_wrseq #(.HOLD(HOLD)) dut (
        .clk       (clk),
        .rst       (rst),
        .cen       (cen),
        .wr        (wr),
        .addr      (addr),
        .din       (din),
        .zero      (zero),
        .busy      (busy),
        .write     (write),
        .dout      (dout),
        .sel_group (sel_group),
        .sel_sub   (sel_sub),
        .up_mult   (up_mult),
        .up_ksl_tl (up_ksl_tl),
        .up_ar_dr  (up_ar_dr),
        .up_sl_rr  (up_sl_rr),
        .up_fnumlo (up_fnumlo),
        .up_fnumhi (up_fnumhi),
        .up_fbcon  (up_fbcon)
    );

    always #5 clk = ~clk;

    // The register store's own slot counter; it is never reset by rst, so a
    // mid-run reset leaves the sequencer out of step until the next zero.
    int st = 0;
    always @(posedge clk) if (cen) st <= (st + 1) % NSLOT;
    assign zero = (st == 0);

    // ---------------- reference model ----------------
    int         m_slot = 0;
    logic [7:0] m_aq = 8'h00;
    logic       m_busy = 1'b0, m_write = 1'b0, m_wait = 1'b0;
    logic [7:0] m_dout = 8'h00;
    logic [1:0] m_grp = 2'd0;
    logic [2:0] m_sub = 3'd0;
    logic [6:0] m_up = 7'd0;
    int         m_rem = 0;

    int         n_slot, n_rem, mc_cur, mc_kind, mc_g, mc_s;
    logic [7:0] n_aq, n_dout;
    logic       n_busy, n_write, n_wait;
    logic [1:0] n_grp;
    logic [2:0] n_sub;
    logic [6:0] n_up;

    // kind: 0 mult, 1 ksl_tl, 2 ar_dr, 3 sl_rr, 4 fnumlo, 5 fnumhi, 6 fbcon, -1 none
    function automatic void mdec(input logic [7:0] a, output int kind, output int g, output int s);
        int hi;
        int o;
        hi   = int'(a) / 16;
        kind = -1;
        g    = 0;
        s    = 0;
        if (hi >= 2 && hi <= 9) begin
            o = int'(a) % 32;
            if (o / 8 < 3 && o % 8 < 6) begin
                kind = (hi - 2) / 2;
                g    = o / 8;
                s    = o % 8;
            end
        end else if (hi >= 10 && hi <= 12) begin
            o = int'(a) % 16;
            if (o <= 8) begin
                kind = 4 + hi - 10;
                g    = o / 3;
                s    = o % 3;
            end
        end
    endfunction

    always_comb begin
        n_slot  = m_slot;
        n_aq    = m_aq;
        n_busy  = m_busy;
        n_write = 1'b0;
        n_dout  = m_dout;
        n_grp   = m_grp;
        n_sub   = m_sub;
        n_up    = m_up;
        n_wait  = m_wait;
        n_rem   = m_rem;
        mc_cur  = zero ? 0 : m_slot;
        mc_kind = -1;
        mc_g    = 0;
        mc_s    = 0;
        mdec(m_aq, mc_kind, mc_g, mc_s);
        if (rst) begin
            n_slot = 0;  n_aq = 8'h00; n_busy = 1'b0; n_dout = 8'h00;
            n_grp = 2'd0; n_sub = 3'd0; n_up = 7'd0;  n_wait = 1'b0; n_rem = 0;
        end else begin
            if (wr && !addr) n_aq = din;
            if (cen) n_slot = (mc_cur + 1) % NSLOT;
            if (m_busy && cen) begin
                if (m_wait) begin
                    if (mc_cur == int'(m_grp) * 6 + int'(m_sub)) begin
                        n_wait = 1'b0;
                        n_rem  = HOLD + 1;
                    end
                end else begin
                    n_rem = m_rem - 1;
                    if (n_rem == 0) begin
                        n_busy = 1'b0;
                        n_up   = 7'd0;
                    end
                end
            end
            if (!m_busy && wr && addr && mc_kind >= 0) begin
                n_busy  = 1'b1;
                n_write = 1'b1;
                n_dout  = din;
                n_grp   = 2'(mc_g);
                n_sub   = 3'(mc_s);
                n_up    = 7'(1 << mc_kind);
                n_wait  = 1'b1;
            end
        end
    end

    always @(posedge clk) begin
        m_slot  <= n_slot;
        m_aq    <= n_aq;
        m_busy  <= n_busy;
        m_write <= n_write;
        m_dout  <= n_dout;
        m_grp   <= n_grp;
        m_sub   <= n_sub;
        m_up    <= n_up;
        m_wait  <= n_wait;
        m_rem   <= n_rem;
    end

    // ---------------- stimulus and checking ----------------
    int   n_tests = 0;
    int   n_fail = 0;
    int   wr_pulses = 0;
    int   busy_cens = 0;
    logic chk_on = 1'b0;
    logic ph = 1'b0;
    int   s0, b0;

    function automatic logic [6:0] ups();
        return {up_fbcon, up_fnumhi, up_fnumlo, up_sl_rr, up_ar_dr, up_ksl_tl, up_mult};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clk: compare against the model, then drive the next edge's inputs.
    task automatic cyc(input logic w, input logic a, input logic [7:0] d, input logic c, input logic r);
        logic [22:0] act, exp;
        @(negedge clk);
        if (chk_on) begin
            act = {busy, write, dout, sel_group, sel_sub, ups()};
            exp = {m_busy, m_write, m_dout, m_grp, m_sub, m_up};
            chk("model", 32'(act), 32'(exp));
            if (write) wr_pulses++;
            if (c && busy) busy_cens++;
        end
        wr = w; addr = a; din = d; cen = c; rst = r;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            ph = !ph;
            cyc(1'b0, 1'b0, 8'h00, ph, 1'b0);
        end
    endtask

    // Stop with the store at slot s and no cen pending on the next edge.
    task automatic wait_slot(input int s);
        for (int i = 0; i < 200; i++) begin
            if (st == s && !cen) break;
            ph = !ph;
            cyc(1'b0, 1'b0, 8'h00, ph, 1'b0);
        end
        chk("wait_slot", 32'(st), 32'(s));
    endtask

    task automatic wait_release();
        for (int i = 0; i < 200; i++) begin
            if (!busy) break;
            idle(1);
        end
        chk("release", 32'(busy), 32'd0);
    endtask

    task automatic bus(input logic [7:0] a, input logic [7:0] d);
        cyc(1'b1, 1'b0, a, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, d, 1'b0, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            ph = !ph;
            cyc(1'b0, 1'b0, 8'h00, ph, 1'b1);
        end
        chk_on = 1'b1;
        idle(1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_write", 32'(write), 32'd0);
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_sel", 32'({sel_group, sel_sub}), 32'd0);
        chk("rst_up", 32'(ups()), 32'd0);

        // MULT slot 0/0, accepted with the store at slot 1: 17 idle cens,
        // the match cen and HOLD+1 cens afterwards.
        wait_slot(0);
        wait_slot(1);
        s0 = wr_pulses; b0 = busy_cens;
        bus(8'h20, 8'h41);
        idle(1);
        chk("mult_up", 32'(ups()), 32'h01);
        chk("mult_sel", 32'({sel_group, sel_sub}), 32'd0);
        chk("mult_dout", 32'(dout), 32'h41);
        chk("mult_busy", 32'(busy), 32'd1);
        wait_release();
        chk("mult_wr", 32'(wr_pulses - s0), 32'd1);
        chk("mult_cens", 32'(busy_cens - b0), 32'd22);

        // KSL_TL at the last slot, accepted at slot 0.
        wait_slot(0);
        s0 = wr_pulses; b0 = busy_cens;
        bus(8'h55, 8'h3F);
        idle(1);
        chk("ksl_up", 32'(ups()), 32'h02);
        chk("ksl_sel", 32'({sel_group, sel_sub}), 32'({2'd2, 3'd5}));
        wait_release();
        chk("ksl_cens", 32'(busy_cens - b0), 32'd22);

        // FNUMHI ch8, second data write while busy is dropped.
        wait_slot(3);
        s0 = wr_pulses;
        bus(8'hB8, 8'h2A);
        idle(2);
        cyc(1'b1, 1'b1, 8'h11, 1'b0, 1'b0);
        idle(2);
        chk("fnhi_up", 32'(ups()), 32'h20);
        chk("fnhi_sel", 32'({sel_group, sel_sub}), 32'({2'd2, 3'd2}));
        chk("fnhi_dout", 32'(dout), 32'h2A);
        wait_release();
        chk("fnhi_wr", 32'(wr_pulses - s0), 32'd1);

        // Holes: nothing accepted, dout untouched.
        s0 = wr_pulses;
        bus(8'h26, 8'h99);
        bus(8'hD0, 8'h77);
        idle(2);
        chk("hole_busy", 32'(busy), 32'd0);
        chk("hole_up", 32'(ups()), 32'd0);
        chk("hole_wr", 32'(wr_pulses - s0), 32'd0);
        chk("hole_dout", 32'(dout), 32'h2A);

        // Reset in WAIT.
        wait_slot(9);
        bus(8'hC4, 8'h0F);
        idle(3);
        chk("fbcon_up", 32'(ups()), 32'h40);
        chk("fbcon_sel", 32'({sel_group, sel_sub}), 32'({2'd1, 3'd1}));
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        idle(1);
        chk("rst2_busy", 32'(busy), 32'd0);
        chk("rst2_up", 32'(ups()), 32'd0);
        chk("rst2_dout", 32'(dout), 32'd0);
        cyc(1'b1, 1'b1, 8'h55, 1'b0, 1'b0);
        idle(1);
        chk("rst2_addr", 32'(busy), 32'd0);

        // cen frozen for 10 clk during WAIT, address write latched meanwhile.
        s0 = wr_pulses;
        bus(8'h8A, 8'h5C);
        idle(3);
        chk("slrr_up", 32'(ups()), 32'h08);
        for (int i = 0; i < 10; i++) begin
            if (i == 4) cyc(1'b1, 1'b0, 8'h01, 1'b0, 1'b0);
            else        cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        end
        chk("frz_busy", 32'(busy), 32'd1);
        wait_release();
        chk("frz_up", 32'(ups()), 32'd0);
        cyc(1'b1, 1'b1, 8'h33, 1'b0, 1'b0);
        idle(2);
        chk("frz_addr", 32'(busy), 32'd0);
        chk("frz_wr", 32'(wr_pulses - s0), 32'd1);

        idle(4);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
